// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : RV32M multi-cycle multiply / restoring-divide execute unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_mul  = 3'd1;
  localparam logic [2:0] c_st_iter = 3'd2;
  localparam logic [2:0] c_st_fix  = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;

  localparam int                 c_cnt_w = $clog2(XLEN);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(XLEN - 1);

  logic [2:0]         r_state, w_next;
  logic [1:0]         r_op;
  logic [XLEN-1:0]    r_a, r_b, r_rem, r_result;
  logic [c_cnt_w-1:0] r_count;
  logic               r_neg_q, r_neg_r;

  logic               w_accept, w_sgn_div, w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0]    w_abs_a, w_abs_b, w_special_res;
  logic               w_sa, w_sb;
  logic [2*XLEN-1:0]  w_mul_a, w_mul_b, w_prod;
  logic [XLEN-1:0]    w_mul_res;
  logic [XLEN:0]      w_shift, w_sub;
  logic               w_qbit;
  logic [XLEN-1:0]    w_q, w_r, w_fix_res;

  assign w_accept   = start & ~kill & ((r_state == c_st_idle) | (r_state == c_st_done));
  assign w_sgn_div  = ~op[0];
  assign w_div_zero = (operand_b == '0);
  assign w_ovf      = w_sgn_div & (operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (operand_b == '1);
  assign w_special  = op[2] & (w_div_zero | w_ovf);
  assign w_abs_a    = (w_sgn_div & operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign w_abs_b    = (w_sgn_div & operand_b[XLEN-1]) ? -operand_b : operand_b;
  // Overflow case: DIV yields the dividend itself (0x80000000), REM yields 0.
  assign w_special_res = w_div_zero ? (op[1] ? operand_a : '1)
                                    : (op[1] ? '0 : operand_a);

  // Sign-extending both to 2*XLEN lets a plain unsigned multiply give the exact low 2*XLEN bits.
  assign w_sa      = ~(r_op[1] & r_op[0]);
  assign w_sb      = ~r_op[1];
  assign w_mul_a   = {{XLEN{w_sa & r_a[XLEN-1]}}, r_a};
  assign w_mul_b   = {{XLEN{w_sb & r_b[XLEN-1]}}, r_b};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // r_a doubles as the dividend shifter and the quotient accumulator.
  assign w_shift = {r_rem, r_a[XLEN-1]};
  assign w_sub   = w_shift - {1'b0, r_b};
  assign w_qbit  = ~w_sub[XLEN];

  assign w_q       = r_neg_q ? -r_a : r_a;
  assign w_r       = r_neg_r ? -r_rem : r_rem;
  assign w_fix_res = r_op[1] ? w_r : w_q;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (kill) begin
      w_next = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          if (!start)         w_next = c_st_idle;
          else if (!op[2])    w_next = c_st_mul;
          else if (w_special) w_next = c_st_done;
          else                w_next = c_st_iter;
        end
        c_st_mul:  w_next = c_st_done;
        c_st_iter: w_next = (r_count == c_last) ? c_st_fix : c_st_iter;
        c_st_fix:  w_next = c_st_done;
        default:   w_next = c_st_idle;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (!rst) begin
      busy = start | (r_state == c_st_mul) | (r_state == c_st_iter) | (r_state == c_st_fix);
    end
    done = (r_state == c_st_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_count  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= op[1:0];
      r_a     <= op[2] ? w_abs_a : operand_a;
      r_b     <= op[2] ? w_abs_b : operand_b;
      r_rem   <= '0;
      r_count <= '0;
      r_neg_q <= w_sgn_div & (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
      r_neg_r <= w_sgn_div & operand_a[XLEN-1];
      if (w_special) r_result <= w_special_res;
    end else if (!kill) begin
      case (r_state)
        c_st_mul: r_result <= w_mul_res;
        c_st_iter: begin
          r_rem   <= w_qbit ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
          r_a     <= {r_a[XLEN-2:0], w_qbit};
          r_count <= r_count + c_cnt_w'(1);
        end
        c_st_fix: r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit: latency, busy window, kill, reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    int          due;
  } sb_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] result;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;
  sb_t         sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sb_t e;
    if (!rst && done === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done cycle=%0d result=%h required no done", cyc, result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || cyc != e.due) begin
          n_err++;
          $display("FAIL done_result cycle=%0d result=%h required %h at cycle %0d",
                   cyc, result, e.res, e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d required test sequence to end", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input logic expect_done);
    sb_t e;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    e.res = exp; e.due = cyc + lat;
    if (expect_done) sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; kill = 1'b0; op = 3'b000;
    operand_a = 32'd5; operand_b = 32'd6;
    repeat (3) tick();
    n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy busy=%b required 0", busy); end
    n_vec++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done done=%b required 0", done); end
    n_vec++; if (result !== '0)   begin n_err++; $display("FAIL reset_result result=%h required 0", result); end
    rst = 1'b0; start = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL idle_busy busy=%b required 0", busy); end
  endtask

  task automatic test_mul();
    vec_t v[4];
    v[0] = '{3'b000, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB};
    v[1] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[2] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    v[3] = '{3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].exp, 2, 1'b1);
      for (int k = 0; k <= 2; k++) begin
        @(negedge clk);
        n_vec++;
        if (busy !== 1'(k < 2)) begin
          n_err++;
          $display("FAIL mul_busy vec=%0d offset=%0d busy=%b required %b", i, k, busy, k < 2);
        end
        tick();
        start = 1'b0;
      end
      n_vec++;
      if (sb.size() != 0) begin
        n_err++; $display("FAIL mul_no_done vec=%0d pending=%0d required 0", i, sb.size()); sb.delete();
      end
      last_res = v[i].exp;
    end
  endtask

  task automatic test_div();
    vec_t v[6];
    v[0] = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD};
    v[1] = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF};
    v[2] = '{3'b101, 32'd100,       32'd7,        32'd14};
    v[3] = '{3'b111, 32'd100,       32'd7,        32'd2};
    v[4] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    v[5] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].exp, 34, 1'b1);
      for (int k = 0; k <= 34; k++) begin
        @(negedge clk);
        n_vec++;
        if (busy !== 1'(k < 34)) begin
          n_err++;
          $display("FAIL div_busy vec=%0d offset=%0d busy=%b required %b", i, k, busy, k < 34);
        end
        tick();
        start = 1'b0;
      end
      n_vec++;
      if (sb.size() != 0) begin
        n_err++; $display("FAIL div_no_done vec=%0d pending=%0d required 0", i, sb.size()); sb.delete();
      end
      last_res = v[i].exp;
    end
  endtask

  task automatic test_div_special();
    vec_t v[4];
    v[0] = '{3'b101, 32'd5,         32'd0,        32'hFFFF_FFFF};
    v[1] = '{3'b110, 32'd5,         32'd0,        32'd5};
    v[2] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[3] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].exp, 1, 1'b1);
      for (int k = 0; k <= 1; k++) begin
        @(negedge clk);
        n_vec++;
        if (busy !== 1'(k < 1)) begin
          n_err++;
          $display("FAIL special_busy vec=%0d offset=%0d busy=%b required %b", i, k, busy, k < 1);
        end
        tick();
        start = 1'b0;
      end
      n_vec++;
      if (sb.size() != 0) begin
        n_err++; $display("FAIL special_no_done vec=%0d pending=%0d required 0", i, sb.size()); sb.delete();
      end
      last_res = v[i].exp;
    end
  endtask

  task automatic test_kill();
    int n;
    n = cyc;
    issue(3'b101, 32'd1000, 32'd3, 32'd0, 34, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      start = (k == 5);
      kill  = (k == 10);
      if (k == 5) begin op = 3'b000; operand_a = 32'd1; operand_b = 32'd1; end
      if (k <= 10) begin
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL kill_busy_inflight cycle=N+%0d busy=%b required 1", k, busy); end
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL kill_busy busy=%b required 0", busy); end
    n_vec++; if (result !== last_res) begin n_err++; $display("FAIL kill_result result=%h required %h", result, last_res); end
    n_vec++; if (cyc != n + 11) begin n_err++; $display("FAIL kill_timeline cycle=%0d required %0d", cyc, n + 11); end
    issue(3'b000, 32'd6, 32'd7, 32'd42, 2, 1'b1);
    tick();
    start = 1'b0;
    repeat (2) tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL kill_mul_no_done pending=%0d required 0", sb.size()); sb.delete();
    end
    last_res = 32'd42;
  endtask

  task automatic test_back_to_back(input logic with_rst);
    int d;
    issue(3'b000, 32'd3, 32'd4, 32'd12, 2, 1'b1);
    tick();
    start = 1'b0;
    tick();
    d = cyc;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_cycle done=%b required 1", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_in_done busy=%b required 0", busy); end
    issue(3'b101, 32'd9, 32'd3, 32'd3, 34, !with_rst);
    tick();
    start = 1'b0;
    if (!with_rst) begin
      while (cyc < d + 35) tick();
      n_vec++;
      if (sb.size() != 0) begin
        n_err++; $display("FAIL b2b_no_done pending=%0d required 0", sb.size()); sb.delete();
      end
    end else begin
      while (cyc < d + 20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++; if (done !== 1'b0)   begin n_err++; $display("FAIL rst_mid_done done=%b required 0", done); end
      n_vec++; if (result !== '0)   begin n_err++; $display("FAIL rst_mid_result result=%h required 0", result); end
      n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_mid_busy busy=%b required 0", busy); end
      while (cyc < d + 37) tick();
      n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_mid_idle busy=%b required 0", busy); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_kill();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M execute unit for the 5-stage pipeline. It sits in the Execute stage beside the ALU and takes the forwarded `rs1`/`rs2` operands after the ForwardA/ForwardB muxes. It produces MUL/MULH/MULHSU/MULHU results through a two-cycle registered multiplier and DIV/DIVU/REM/REMU results through a radix-2 restoring divider. Its `busy` output is the execute-side mult/div stall source consumed by the hazard unit.

## Interface
- `XLEN`, 32: operand and result width.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only when the FSM is IDLE or DONE.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a`  in  XLEN  rs1 value; sampled with `start`.
- `operand_b`  in  XLEN  rs2 value; sampled with `start`.
- `kill`  in  1  synchronous abort of the in-flight op.
- `busy`  out  1  stall request to the hazard unit (Stall_F/Stall_D).
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered result; held until the next `done`.

## Operation
- FSM states: IDLE, MUL, DIV_ITER, DIV_FIX, DONE. Reset puts the FSM in IDLE and sets `done`=0, `result`=0, and the internal counter and registers to 0.
- Accepting `start` in IDLE or DONE latches `op`, the operands, and the sign flags, then branches:
  - `op[2]`=0 goes to MUL.
  - Divide by zero or signed overflow goes straight to DONE.
  - All other divides go to DIV_ITER with `count`=0.
- Multiply:
  - `operand_a` is sign-extended to 33 bits for op 000/001/010 and zero-extended otherwise.
  - `operand_b` is sign-extended for op 000/001 and zero-extended otherwise.
  - The 33x33 signed product is registered in the MUL state.
  - MUL returns `product[XLEN-1:0]`; the other three return `product[2*XLEN-1:XLEN]`.
  - MUL always transitions to DONE.
- Divide, normal path:
  - For signed ops the magnitudes |a| and |b| are used.
  - Each DIV_ITER cycle shifts the partial remainder left by one, brings in the next dividend MSB, subtracts the divisor if the result is non-negative, and shifts the quotient bit in.
  - After XLEN iterations (`count`=XLEN-1) the FSM moves to DIV_FIX.
  - DIV_FIX negates the quotient if sign(a)≠sign(b) and negates the remainder if sign(a)=1 (signed ops only), then selects the quotient (op 100/101) or the remainder (op 110/111). Next state is DONE.
- Special cases, resolved at accept:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return `operand_a`.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, op 100/110): DIV returns 0x80000000 and REM returns 0.
- DONE asserts `done` for exactly one cycle. The next state is IDLE, or a new op if `start` is high in that cycle (back-to-back issue).
- `busy` = `start` | (state ∈ {MUL, DIV_ITER, DIV_FIX}). It is forced to 0 while `rst` is high.
- `start` arriving in MUL, DIV_ITER or DIV_FIX is ignored: no state change, no latch.
- `kill` forces IDLE on the next edge with no `done` pulse; `result` keeps its previous value. `kill` takes priority over `start` in the same cycle.
- `rst` asserted mid-operation behaves as a full reset at the next edge.

## Timing
- Define cycle N as the cycle in which `start` is sampled high.
- Multiply:
  - `busy`=1 in cycles N and N+1.
  - `done`=1 and `result` valid in N+2.
  - Total latency is 2 cycles.
- Normal divide:
  - `busy`=1 in cycles N through N+33 (DIV_ITER N+1..N+32, DIV_FIX N+33).
  - `done`=1 in N+34.
- Special-case divide: `busy`=1 in cycle N only, and `done`=1 in N+1.
- Because `busy` is low in the `done` cycle, the pipeline advances exactly when the result is valid and the EX/MEM register captures `result` on that edge.
- Back-to-back: with `start` high in the DONE cycle D, the new op counts D as its cycle N.

## Test plan
- MUL with a=0xFFFFFFFD (-3), b=7: `done` at N+2, `result`=0xFFFFFFEB; `busy` high in N and N+1 only.
- MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE. MULH on the same operands gives 0x00000000. MULHSU with a=0xFFFFFFFF, b=2 gives 0xFFFFFFFF.
- DIV with a=0xFFFFFFF9 (-7), b=2 gives 0xFFFFFFFD at `done`=N+34; REM on the same operands gives 0xFFFFFFFF. DIVU 100/7 gives 14 and REMU gives 2. `busy` must be high in exactly N..N+33.
- DIVU 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5, both with `done` at N+1. DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0, both with `done` at N+1.
- DIV started at N, second `start` pulsed at N+5 (ignored), `kill` at N+10:
  - No `done` ever appears for that op, `busy`=0 at N+11, and `result` is unchanged.
  - A fresh MUL 6×7 started at N+11 returns 42 at N+13.
- Back-to-back: MUL 3×4 gives 12 at `done` cycle D, with a DIVU 9/3 started in D giving 3 at D+34. `rst` raised at D+20 yields IDLE, `done`=0, `result`=0, `busy`=0 from the next cycle.
